// File: rtl/hfswr_bram_pkg.sv
// Shared definitions for the PS<->PL BRAM mailbox logic: FSM state type,
// default mailbox word addresses, default BRAM read latency and an address helper.
package hfswr_bram_pkg;

    // Mailbox reader control states
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_FLAG_RD    = 3'd1,
        ST_FLAG_WAIT  = 3'd2,
        ST_PARAM_RD   = 3'd3,
        ST_PARAM_WAIT = 3'd4,
        ST_PRESENT    = 3'd5,
        ST_ACK        = 3'd6
    } state_t;

    // Mailbox occupies the top words of the shared BRAM
    localparam int unsigned MBOX_PARAM_BASE = 2040;
    localparam int unsigned MBOX_FLAG_ADDR  = 2046;
    localparam int unsigned MBOX_RSVD_ADDR  = 2047;   // last mailbox word, kept free

    // Default BRAM read latency (address cycle to data cycle)
    localparam int unsigned BRAM_RD_LAT = 2;

    // True when addr lies inside the n-word window starting at base
    function automatic logic addr_in_range(input logic [31:0] addr,
                                           input logic [31:0] base,
                                           input int unsigned n);
        return (addr >= base) && ((addr - base) < n);
    endfunction

endpackage

// File: rtl/bram_cmd_reader_if.sv
// BRAM port plus command valid/ready bundle between the mailbox reader
// (master) and the BRAM / command consumer side (slave).
interface bram_cmd_reader_if #(
    parameter int unsigned NPARAM = 4
) ();
    logic                    bram_en;
    logic                    bram_we;
    logic [31:0]             bram_addr;
    logic [31:0]             bram_din;
    logic [31:0]             bram_dout;
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [32*NPARAM-1:0]    cmd_params;
    logic [7:0]              cmd_cnt;
    logic                    busy;

    modport master (
        output bram_en, bram_we, bram_addr, bram_din,
        input  bram_dout,
        output cmd_valid, cmd_params, cmd_cnt, busy,
        input  cmd_ready
    );

    modport slave (
        input  bram_en, bram_we, bram_addr, bram_din,
        output bram_dout,
        input  cmd_valid, cmd_params, cmd_cnt, busy,
        output cmd_ready
    );
endinterface

// File: rtl/bram_cmd_reader_fetch.sv
// Single-word BRAM read engine: a start pulse drives bram_en/addr for exactly
// one cycle; done pulses RD_LAT cycles after that cycle, aligned with rdata.
module bram_word_fetch
    import hfswr_bram_pkg::*;
#(
    parameter int unsigned RD_LAT = BRAM_RD_LAT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] start_addr,
    output logic        bram_en,
    output logic [31:0] bram_addr,
    input  logic [31:0] bram_dout,
    output logic [31:0] rdata,
    output logic        done
);
    logic              en_q,   en_d;
    logic [31:0]       addr_q, addr_d;
    logic [RD_LAT-1:0] lat_q,  lat_d;   // lat_q[k] is high k+1 cycles after the address cycle

    // Address/enable for the issue cycle; address returns to 0 when idle
    always_comb begin
        en_d   = start;
        addr_d = start ? start_addr : 32'd0;
    end

    // Latency tracker: shift the issue marker along RD_LAT stages
    assign lat_d[0] = en_q;
    generate
        for (genvar gi = 1; gi < RD_LAT; gi++) begin : g_lat
            assign lat_d[gi] = lat_q[gi-1];
        end
    endgenerate

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q   <= 1'b0;
            addr_q <= 32'd0;
            lat_q  <= '0;
        end else begin
            en_q   <= en_d;
            addr_q <= addr_d;
            lat_q  <= lat_d;
        end
    end

    assign bram_en   = en_q;
    assign bram_addr = addr_q;
    assign rdata     = bram_dout;
    assign done      = lat_q[RD_LAT-1];
endmodule

// File: rtl/bram_cmd_reader.sv
// PS->PL command mailbox reader: polls the flag word, fetches the parameter
// block word by word, presents it on valid/ready, then clears the flag as ack.
module bram_cmd_reader
    import hfswr_bram_pkg::*;
#(
    parameter int unsigned FLAG_ADDR  = MBOX_FLAG_ADDR,
    parameter int unsigned PARAM_BASE = MBOX_PARAM_BASE,
    parameter int unsigned NPARAM     = 4,
    parameter int unsigned RD_LAT     = BRAM_RD_LAT,
    parameter int unsigned POLL_DIV   = 64,
    parameter int unsigned ACK_HOLD   = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    bram_cmd_reader_if.master io
);
    localparam int unsigned PW = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
    localparam int unsigned HW = (ACK_HOLD > 1) ? $clog2(ACK_HOLD) : 1;
    localparam int unsigned IW = (NPARAM   > 1) ? $clog2(NPARAM)   : 1;
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_DIV - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(ACK_HOLD - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NPARAM - 1);

    // Configuration sanity: parameter block must not overlap the flag or reserved word
    generate
        if (NPARAM < 1 || NPARAM > 8) begin : g_bad_nparam
            $error("bram_cmd_reader: NPARAM must be 1..8");
        end
        if (RD_LAT < 1 || POLL_DIV < 1 || ACK_HOLD < 1) begin : g_bad_timing
            $error("bram_cmd_reader: RD_LAT, POLL_DIV and ACK_HOLD must be >= 1");
        end
        if (addr_in_range(FLAG_ADDR, PARAM_BASE, NPARAM)) begin : g_bad_flag
            $error("bram_cmd_reader: parameter block overlaps FLAG_ADDR");
        end
        if (addr_in_range(MBOX_RSVD_ADDR, PARAM_BASE, NPARAM)) begin : g_bad_rsvd
            $error("bram_cmd_reader: parameter block overlaps the reserved mailbox word");
        end
    endgenerate

    state_t               state_q,  state_d;
    logic [PW-1:0]        poll_q,   poll_d;
    logic [HW-1:0]        hold_q,   hold_d;
    logic [IW-1:0]        idx_q,    idx_d;
    logic [32*NPARAM-1:0] params_q, params_d;
    logic [7:0]           cnt_q,    cnt_d;
    logic                 valid_q,  valid_d;
    logic                 busy_q,   busy_d;
    logic                 ack_q,    ack_d;

    logic        fetch_start;
    logic [31:0] fetch_addr;
    logic        fetch_bram_en;
    logic [31:0] fetch_bram_addr;
    logic [31:0] fetch_rdata;
    logic        fetch_done;

    bram_word_fetch #(
        .RD_LAT(RD_LAT)
    ) u_fetch (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (fetch_start),
        .start_addr(fetch_addr),
        .bram_en   (fetch_bram_en),
        .bram_addr (fetch_bram_addr),
        .bram_dout (io.bram_dout),
        .rdata     (fetch_rdata),
        .done      (fetch_done)
    );

    // Next-state logic: poll, flag check, sequential param reads, present, ack
    always_comb begin
        state_d     = state_q;
        poll_d      = poll_q;
        hold_d      = hold_q;
        idx_d       = idx_q;
        params_d    = params_q;
        cnt_d       = cnt_q;
        valid_d     = valid_q;
        fetch_start = 1'b0;
        fetch_addr  = 32'd0;
        case (state_q)
            ST_IDLE: begin
                if (!en) begin
                    poll_d = '0;
                end else if (poll_q == POLL_LAST) begin
                    poll_d      = '0;
                    fetch_start = 1'b1;
                    fetch_addr  = FLAG_ADDR;
                    state_d     = ST_FLAG_RD;
                end else begin
                    poll_d = poll_q + 1'b1;
                end
            end
            ST_FLAG_RD: state_d = ST_FLAG_WAIT;
            ST_FLAG_WAIT: begin
                // Only bit0 of the flag word carries meaning
                if (fetch_done) begin
                    if (fetch_rdata[0]) begin
                        idx_d       = '0;
                        fetch_start = 1'b1;
                        fetch_addr  = PARAM_BASE;
                        state_d     = ST_PARAM_RD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_PARAM_RD: state_d = ST_PARAM_WAIT;
            ST_PARAM_WAIT: begin
                if (fetch_done) begin
                    params_d[32*idx_q +: 32] = fetch_rdata;
                    if (idx_q == IDX_LAST) begin
                        valid_d = 1'b1;
                        state_d = ST_PRESENT;
                    end else begin
                        idx_d       = idx_q + 1'b1;
                        fetch_start = 1'b1;
                        fetch_addr  = PARAM_BASE + 32'(idx_q) + 32'd1;
                        state_d     = ST_PARAM_RD;
                    end
                end
            end
            ST_PRESENT: begin
                if (valid_q && io.cmd_ready) begin
                    valid_d = 1'b0;
                    cnt_d   = cnt_q + 8'd1;
                    hold_d  = '0;
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                if (hold_q == HOLD_LAST) begin
                    poll_d  = '0;
                    state_d = ST_IDLE;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
        ack_d  = (state_d == ST_ACK);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            poll_q   <= '0;
            hold_q   <= '0;
            idx_q    <= '0;
            params_q <= '0;
            cnt_q    <= 8'd0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            poll_q   <= poll_d;
            hold_q   <= hold_d;
            idx_q    <= idx_d;
            params_q <= params_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            ack_q    <= ack_d;
        end
    end

    // The clear write owns the port during ACK; reads own it otherwise
    assign io.bram_en    = fetch_bram_en | ack_q;
    assign io.bram_we    = ack_q;
    assign io.bram_addr  = ack_q ? FLAG_ADDR : fetch_bram_addr;
    assign io.bram_din   = 32'd0;
    assign io.cmd_valid  = valid_q;
    assign io.cmd_params = params_q;
    assign io.cmd_cnt    = cnt_q;
    assign io.busy       = busy_q;
endmodule

// File: tb/tb_bram_cmd_reader.sv
// Bench for bram_cmd_reader: dual-port BRAM model (PS side + DUT side),
// bus monitor, and a directed sequence driving random command payloads.
module tb_bram_cmd_reader;
    localparam int NP = 4, RDL = 2, PD = 64, AH = 3;
    localparam logic [31:0] FA = 32'd2046, PB = 32'd2040;
    localparam logic [10:0] FA_IX = 11'd2046, PB_IX = 11'd2040;
    localparam int LAT    = (NP + 1) * (RDL + 1);   // flag read to cmd_valid
    localparam int PERIOD = PD + RDL + 1;           // flag poll period with flag=0

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;

    bram_cmd_reader_if #(.NPARAM(NP)) io ();

    bram_cmd_reader #(
        .FLAG_ADDR(FA), .PARAM_BASE(PB), .NPARAM(NP),
        .RD_LAT(RDL), .POLL_DIV(PD), .ACK_HOLD(AH)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (en),
        .io   (io)
    );

    always #5 clk = ~clk;

    // Shared BRAM: PS writes on port B, DUT reads/writes on port A
    logic [31:0] mem [0:2047];
    logic [31:0] rd_pipe [0:RDL-1];
    logic        ps_we = 1'b0;
    logic [10:0] ps_addr = '0;
    logic [31:0] ps_wdata = '0;

    always @(posedge clk) begin
        if (ps_we) mem[ps_addr] <= ps_wdata;
        if (io.bram_en && io.bram_we) mem[io.bram_addr[10:0]] <= io.bram_din;
        rd_pipe[0] <= (io.bram_en && !io.bram_we) ? mem[io.bram_addr[10:0]] : 32'hDEAD_BEEF;
        for (int k = 1; k < RDL; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign io.bram_dout = rd_pipe[RDL-1];

    // Bus monitor
    int   cyc = 0;
    int   flag_rd_cnt = 0, param_rd_cnt = 0, wr_cnt = 0, wr_bad = 0;
    int   ack_bursts = 0, last_flag_cyc = 0, valid_cnt = 0;
    logic we_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (io.bram_en && !io.bram_we) begin
            if (io.bram_addr == FA) begin
                flag_rd_cnt   <= flag_rd_cnt + 1;
                last_flag_cyc <= cyc;
            end else if (io.bram_addr >= PB && io.bram_addr < PB + NP) begin
                param_rd_cnt <= param_rd_cnt + 1;
            end
        end
        if (io.bram_we) begin
            wr_cnt <= wr_cnt + 1;
            if (!io.bram_en || io.bram_addr != FA || io.bram_din != 32'd0) wr_bad <= wr_bad + 1;
            if (!we_prev) ack_bursts <= ack_bursts + 1;
        end
        if (io.cmd_valid) valid_cnt <= valid_cnt + 1;
        we_prev <= io.bram_en && io.bram_we;
    end

    // Checking
    int n_checks = 0, n_pass = 0, n_fail = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Reference model: expected payload and accepted-command count
    logic [127:0] exp_params = '0;
    int           exp_cnt = 0;

    task automatic ps_write(input logic [10:0] a, input logic [31:0] d);
        ps_addr = a; ps_wdata = d; ps_we = 1'b1;
        step();
        ps_we = 1'b0;
    endtask

    task automatic post_random();
        logic [31:0] w, f;
        for (int i = 0; i < NP; i++) begin
            w = $urandom();
            exp_params[32*i +: 32] = w;
            ps_write(PB_IX + 11'(i), w);
        end
        f = $urandom();
        f[0] = 1'b1;             // upper flag bits are don't-care
        ps_write(FA_IX, f);
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (io.cmd_valid) begin ok = 1'b1; break; end
            step();
        end
    endtask

    task automatic wait_flag_clear(input int budget, output bit ok);
        logic [31:0] f;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            f = mem[FA_IX];
            if (!f[0]) begin ok = 1'b1; break; end
            step();
        end
    endtask

    task automatic wait_flag_rd(input int budget, output int c, output bit ok);
        int start;
        start = flag_rd_cnt; ok = 1'b0; c = 0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (flag_rd_cnt != start) begin ok = 1'b1; c = last_flag_cyc; break; end
        end
    endtask

    // Wait for a posted command with cmd_ready=1 and check presentation and ack
    task automatic finish_cmd(input string tag);
        bit ok;
        int a0, lat;
        a0 = ack_bursts;
        wait_valid(3 * PERIOD, ok);
        lat = ok ? (cyc - last_flag_cyc) : -1;
        check({tag, " latency"}, 128'(lat), 128'(LAT));
        check({tag, " params"}, io.cmd_params, exp_params);
        exp_cnt++;
        wait_flag_clear(20, ok);
        repeat (3) step();
        check({tag, " ack once"}, 128'(ack_bursts - a0), 128'(1));
        check({tag, " cmd_cnt"}, 128'(io.cmd_cnt), 128'(exp_cnt % 256));
    endtask

    initial begin
        bit ok;
        int c0, c1, c2, f0, p0, w0, v0, a0;
        logic [31:0] r;
        logic stable;

        io.cmd_ready = 1'b1;
        repeat (3) step();
        check("reset ctrl", 128'({io.busy, io.bram_en, io.bram_we, io.cmd_valid,
                                  io.bram_din, io.bram_addr, io.cmd_cnt}), 128'(0));
        check("reset params", io.cmd_params, 128'(0));
        r = $urandom(); r[0] = 1'b0;
        ps_write(FA_IX, r);
        rst_n = 1'b1;

        // T1: idle polling with flag=0
        en = 1'b1;
        p0 = param_rd_cnt; w0 = wr_cnt; v0 = valid_cnt;
        wait_flag_rd(2 * PERIOD, c0, ok);
        check("T1 first poll", 128'(ok), 128'(1));
        wait_flag_rd(2 * PERIOD, c1, ok);
        wait_flag_rd(2 * PERIOD, c2, ok);
        check("T1 period a", 128'(c1 - c0), 128'(PERIOD));
        check("T1 period b", 128'(c2 - c1), 128'(PERIOD));
        check("T1 no param reads", 128'(param_rd_cnt - p0), 128'(0));
        check("T1 no writes", 128'(wr_cnt - w0), 128'(0));
        check("T1 no valid", 128'(valid_cnt - v0), 128'(0));

        // T2: directed payload, consumer always ready
        for (int i = 0; i < NP; i++) begin
            r = 32'h11 * (i + 1);
            exp_params[32*i +: 32] = r;
            ps_write(PB_IX + 11'(i), r);
        end
        ps_write(FA_IX, 32'd1);
        check("T2 model", exp_params, 128'h00000044_00000033_00000022_00000011);
        w0 = wr_cnt; v0 = valid_cnt;
        finish_cmd("T2");
        check("T2 valid cycles", 128'(valid_cnt - v0), 128'(1));
        check("T2 write cycles", 128'(wr_cnt - w0), 128'(AH));

        // T3: consumer stalls 20 cycles
        io.cmd_ready = 1'b0;
        post_random();
        wait_valid(3 * PERIOD, ok);
        check("T3 valid", 128'(ok), 128'(1));
        w0 = wr_cnt; stable = 1'b1;
        repeat (20) begin
            step();
            if (io.cmd_valid !== 1'b1 || io.cmd_params !== exp_params) stable = 1'b0;
        end
        check("T3 held stable", 128'(stable), 128'(1));
        check("T3 no early write", 128'(wr_cnt - w0), 128'(0));
        io.cmd_ready = 1'b1;
        step();
        exp_cnt++;
        check("T3 valid drop", 128'(io.cmd_valid), 128'(0));
        check("T3 cmd_cnt", 128'(io.cmd_cnt), 128'(exp_cnt % 256));
        wait_flag_clear(20, ok);
        repeat (3) step();
        check("T3 ack writes", 128'(wr_cnt - w0), 128'(AH));

        // T4: reset while waiting on parameter word 2
        post_random();
        p0 = param_rd_cnt; ok = 1'b0;
        for (int i = 0; i < 3 * PERIOD; i++) begin
            step();
            if (param_rd_cnt - p0 == 3) begin ok = 1'b1; break; end
        end
        check("T4 reach word2", 128'(ok), 128'(1));
        step();
        rst_n = 1'b0;
        #1;
        check("T4 reset ctrl", 128'({io.busy, io.bram_en, io.bram_we, io.cmd_valid,
                                     io.bram_din, io.bram_addr, io.cmd_cnt}), 128'(0));
        check("T4 reset params", io.cmd_params, 128'(0));
        r = mem[FA_IX];
        check("T4 flag kept", 128'(r[0]), 128'(1));
        exp_cnt = 0;
        step(); step();
        rst_n = 1'b1;
        finish_cmd("T4 replay");

        // T5: 256 back-to-back commands from a fresh reset
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        exp_cnt = 0;
        a0 = ack_bursts;
        for (int n = 0; n < 256; n++) begin
            post_random();
            finish_cmd($sformatf("T5 cmd%0d", n));
        end
        check("T5 wrap", 128'(io.cmd_cnt), 128'(0));
        check("T5 acks", 128'(ack_bursts - a0), 128'(256));

        // T6: en dropped while presenting
        io.cmd_ready = 1'b0;
        post_random();
        wait_valid(3 * PERIOD, ok);
        check("T6 valid", 128'(ok), 128'(1));
        check("T6 params", io.cmd_params, exp_params);
        en = 1'b0;
        a0 = ack_bursts;
        repeat (4) step();
        io.cmd_ready = 1'b1;
        exp_cnt++;
        wait_flag_clear(20, ok);
        check("T6 flag cleared", 128'(ok), 128'(1));
        repeat (3) step();
        check("T6 ack", 128'(ack_bursts - a0), 128'(1));
        check("T6 cmd_cnt", 128'(io.cmd_cnt), 128'(exp_cnt % 256));
        f0 = flag_rd_cnt;
        repeat (3 * PERIOD) step();
        check("T6 no polls", 128'(flag_rd_cnt - f0), 128'(0));
        check("T6 idle", 128'(io.busy), 128'(0));

        check("write content", 128'(wr_bad), 128'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Hard time bound so the run always ends
    initial begin
        #2000000;
        $display("FAIL watchdog: run exceeded time bound");
        $fatal(1, "watchdog");
    end
endmodule
